// File: rtl/fetch_queue_block.sv
// Instruction prefetch queue. It issues sequential program-memory reads, buffers the
// returned {instruction, address} pairs in a FIFO, and flushes everything on a redirect.
module fetch_queue_block #(
    parameter int unsigned         ADDR_W   = 16,
    parameter int unsigned         INS_W    = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           mem_en,
    input  logic [INS_W-1:0]               mem_data,
    input  logic                           pc_mux_sel,
    input  logic [ADDR_W-1:0]              jmp_loc,
    output logic [INS_W-1:0]               ins,
    output logic [ADDR_W-1:0]              ins_addr,
    output logic                           ins_valid,
    input  logic                           ins_ready,
    output logic [$clog2(DEPTH+1)-1:0]     q_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              inflight_q;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [INS_W-1:0]  ins_mem  [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic redirect;
    logic credit_ok;
    logic issue;
    logic wr;
    logic pop;

    // The in-flight request is counted as occupied so its response always has a free slot.
    always_comb begin
        redirect  = pc_mux_sel && !reset;
        credit_ok = ({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH);
        issue     = !reset && (pc_mux_sel || credit_ok);
        mem_en    = issue;
        mem_addr  = redirect ? jmp_loc : pc_q;
        ins_valid = !reset && (count_q != '0) && !pc_mux_sel;
        pop       = ins_valid && ins_ready;
        wr        = inflight_q && !pc_mux_sel;
        ins       = reset ? '0 : ins_mem[rptr_q];
        ins_addr  = reset ? '0 : addr_mem[rptr_q];
        q_count   = reset ? '0 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ins_mem[i]  <= '0;
                addr_mem[i] <= '0;
            end
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_addr_q <= mem_addr;
                pc_q       <= mem_addr + ADDR_W'(1);
            end
            if (pc_mux_sel) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (wr) begin
                    ins_mem[wptr_q]  <= mem_data;
                    addr_mem[wptr_q] <= req_addr_q;
                    wptr_q           <= wptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(wr) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_block.sv
// Bench for fetch_queue_block: directed reset/stall/redirect cases on the default build,
// then random ready/redirect traffic on DEPTH=2 (RESET_PC=0xFFFE) and DEPTH=8 builds.
module tb_fetch_queue_block;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic        reset, pc_mux_sel, ins_ready, mem_en, ins_valid;
    logic [15:0] jmp_loc, mem_addr, ins_addr;
    logic [31:0] mem_data, ins;
    logic [2:0]  q_count;

    // Random builds share reset/redirect
    logic        reset_r, sel_r, ready_a, ready_b;
    logic [15:0] jmp_r;
    logic        en_a, val_a, en_b, val_b;
    logic [15:0] maddr_a, iaddr_a, maddr_b, iaddr_b;
    logic [31:0] mdat_a, ins_a, mdat_b, ins_b;
    logic [1:0]  qc_a;
    logic [3:0]  qc_b;

    fetch_queue_block dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
        .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .ins(ins), .ins_addr(ins_addr),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .q_count(q_count)
    );

    fetch_queue_block #(.DEPTH(2), .RESET_PC(16'hFFFE)) dut_a (
        .clk(clk), .reset(reset_r), .mem_addr(maddr_a), .mem_en(en_a), .mem_data(mdat_a),
        .pc_mux_sel(sel_r), .jmp_loc(jmp_r), .ins(ins_a), .ins_addr(iaddr_a),
        .ins_valid(val_a), .ins_ready(ready_a), .q_count(qc_a)
    );

    fetch_queue_block #(.DEPTH(8)) dut_b (
        .clk(clk), .reset(reset_r), .mem_addr(maddr_b), .mem_en(en_b), .mem_data(mdat_b),
        .pc_mux_sel(sel_r), .jmp_loc(jmp_r), .ins(ins_b), .ins_addr(iaddr_b),
        .ins_valid(val_b), .ins_ready(ready_b), .q_count(qc_b)
    );

    // Program memories: one-cycle read latency
    always @(posedge clk) begin
        mem_data <= {16'h0000, mem_addr};
        mdat_a   <= {~maddr_a, maddr_a};
        mdat_b   <= {~maddr_b, maddr_b};
    end

    int n_vec = 0;
    int n_err = 0;
    int nd_a  = 0;
    int nd_b  = 0;

    logic [15:0] sb_m[$];
    logic [15:0] sb_a[$];
    logic [15:0] sb_b[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected delivery order after a reset or redirect to 'start': start, start+1, ...
    task automatic load(input int which, input logic [15:0] start);
        case (which)
            0: begin sb_m.delete(); for (int i = 0; i < 64; i++) sb_m.push_back(start + 16'(i)); end
            1: begin sb_a.delete(); for (int i = 0; i < 64; i++) sb_a.push_back(start + 16'(i)); end
            default: begin
                sb_b.delete();
                for (int i = 0; i < 64; i++) sb_b.push_back(start + 16'(i));
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (ins_valid && ins_ready) begin
            if (sb_m.size() == 0) check("m_sb_empty", 1, 0);
            else begin
                e = sb_m.pop_front();
                check("m_ins_addr", ins_addr, e);
                check("m_ins", ins, {16'h0000, e});
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset_r) check("a_qcount_bound", qc_a <= 2'd2, 1);
        if (val_a && ready_a) begin
            nd_a++;
            if (sb_a.size() == 0) check("a_sb_empty", 1, 0);
            else begin
                e = sb_a.pop_front();
                check("a_ins_addr", iaddr_a, e);
                check("a_ins", ins_a, {~e, e});
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset_r) check("b_qcount_bound", qc_b <= 4'd8, 1);
        if (val_b && ready_b) begin
            nd_b++;
            if (sb_b.size() == 0) check("b_sb_empty", 1, 0);
            else begin
                e = sb_b.pop_front();
                check("b_ins_addr", iaddr_b, e);
                check("b_ins", ins_b, {~e, e});
            end
        end
    end

    initial begin
        bit found;
        reset = 1; pc_mux_sel = 0; jmp_loc = 0; ins_ready = 1;
        reset_r = 1; sel_r = 0; jmp_r = 0; ready_a = 1; ready_b = 1;
        repeat (2) step();
        // Redirect request must be ignored while in reset
        pc_mux_sel = 1; jmp_loc = 16'h1234;
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_ins_valid", ins_valid, 0);
        check("rst_q_count", q_count, 0);
        check("rst_ins", ins, 0);
        check("rst_ins_addr", ins_addr, 0);

        // Streaming with ready held high
        step(); pc_mux_sel = 0; reset = 0; load(0, 16'h0000); #1;
        for (int k = 0; k < 8; k++) begin
            check("stream_mem_en", mem_en, 1);
            check("stream_mem_addr", mem_addr, 16'(k));
            check("stream_valid", ins_valid, k >= 2);
            step(); #1;
        end

        // Stall from reset release
        reset = 1; step(); reset = 0; ins_ready = 0; load(0, 16'h0000); #1;
        for (int k = 0; k < 4; k++) begin
            check("stall_issue", {mem_en, mem_addr}, {1'b1, 16'(k)});
            step(); #1;
        end
        check("stall_no_issue", mem_en, 0);
        step(); #1;
        for (int k = 0; k < 4; k++) begin
            check("stall_q_full", q_count, 4);
            check("stall_mem_en", mem_en, 0);
            check("stall_head", {ins_valid, ins_addr}, {1'b1, 16'h0000});
            step(); #1;
        end
        ins_ready = 1;
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            step(); #1;
            if (mem_en) begin
                found = 1;
                check("resume_addr", mem_addr, 16'h0004);
            end
        end
        if (!found) check("resume_timeout", 0, 1);
        repeat (6) step();

        // Redirect with three queued entries and one in flight
        reset = 1; step(); reset = 0; ins_ready = 0; load(0, 16'h0000); #1;
        repeat (4) step();
        #1;
        check("redir_q_before", q_count, 3);
        pc_mux_sel = 1; jmp_loc = 16'h0100; load(0, 16'h0100); #1;
        check("redir_valid", ins_valid, 0);
        check("redir_issue", {mem_en, mem_addr}, {1'b1, 16'h0100});
        step(); pc_mux_sel = 0; ins_ready = 1; #1;
        check("redir_q_flushed", q_count, 0);
        step(); #1;
        check("redir_q_one", q_count, 1);
        check("redir_head", {ins_valid, ins_addr}, {1'b1, 16'h0100});
        repeat (4) step();

        // Reset with two queued entries and one in flight
        reset = 1; step(); reset = 0; ins_ready = 0; load(0, 16'h0000); #1;
        repeat (3) step();
        #1;
        check("mrst_q_before", q_count, 2);
        reset = 1; #1;
        step(); #1;
        check("mrst_q", q_count, 0);
        check("mrst_valid", ins_valid, 0);
        check("mrst_mem_en", mem_en, 0);
        step(); reset = 0; ins_ready = 1; load(0, 16'h0000); #1;
        check("mrst_first_issue", {mem_en, mem_addr}, {1'b1, 16'h0000});
        repeat (8) step();
        reset = 1;

        // Random traffic on the DEPTH=2 / DEPTH=8 builds
        step(); reset_r = 0; load(1, 16'hFFFE); load(2, 16'h0000); #1;
        check("a_first_issue", {en_a, maddr_a}, {1'b1, 16'hFFFE});
        check("b_first_issue", {en_b, maddr_b}, {1'b1, 16'h0000});
        step(); #1;
        check("a_second_issue", {en_a, maddr_a}, {1'b1, 16'hFFFF});
        repeat (12) step();
        check("a_wrap_delivered", nd_a >= 4, 1);
        for (int k = 0; k < 3000; k++) begin
            ready_a = $urandom_range(0, 3) != 0;
            ready_b = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0 || sb_a.size() < 8 || sb_b.size() < 8) begin
                sel_r = 1;
                jmp_r = 16'($urandom);
                load(1, jmp_r);
                load(2, jmp_r);
            end else begin
                sel_r = 0;
            end
            step();
        end
        sel_r = 0; reset_r = 1;
        check("a_throughput", nd_a > 200, 1);
        check("b_throughput", nd_b > 200, 1);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
